// File: rtl/ul_srch_pkg.sv
// +--------------------------------------------------------------------+
// | ul_srch_pkg                                                          |
// | Shared constants, SCS helpers and FSM state type for the UL search   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package ul_srch_pkg;

  localparam logic [1:0] SCS_INV = 2'd0;
  localparam logic [1:0] SCS_5K  = 2'd1;
  localparam logic [1:0] SCS_15K = 2'd2;
  localparam logic [1:0] SCS_30K = 2'd3;

  localparam int NSEG = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SCAN = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic logic [4:0] scs_gap(input logic [1:0] scs);
    case (scs)
      SCS_5K:  scs_gap = 5'd18;
      SCS_15K: scs_gap = 5'd6;
      SCS_30K: scs_gap = 5'd3;
      default: scs_gap = 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] scs_re_limit(input logic [1:0] scs);
    case (scs)
      SCS_5K:  scs_re_limit = 8'd180;
      SCS_15K: scs_re_limit = 8'd60;
      SCS_30K: scs_re_limit = 8'd30;
      default: scs_re_limit = 8'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ul_srch_90k.sv
// +--------------------------------------------------------------------+
// | ul_srch_90k                                                          |
// | Combinational RE index to 90 kHz search segment / offset mapper      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module ul_srch_90k
  import ul_srch_pkg::*;
(
  input  logic [1:0] scs,
  input  logic [7:0] re_index,
  output logic [3:0] seg,
  output logic [4:0] mod
);

  // Constant divisors per SCS keep each branch a fixed-ratio divide.
  always_comb begin
    seg = '0;
    mod = '0;
    case (scs)
      SCS_5K: begin
        seg = 4'(re_index / 8'd18);
        mod = 5'(re_index % 8'd18);
      end
      SCS_15K: begin
        seg = 4'(re_index / 8'd6);
        mod = 5'(re_index % 8'd6);
      end
      SCS_30K: begin
        seg = 4'(re_index / 8'd3);
        mod = 5'(re_index % 8'd3);
      end
      default: begin
        seg = '0;
        mod = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ul_srch_90k_acc.sv
// +--------------------------------------------------------------------+
// | ul_srch_90k_acc                                                      |
// | Per-symbol segment energy accumulator with peak-segment search       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module ul_srch_90k_acc
  import ul_srch_pkg::*;
#(
  parameter int PWR_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       scs,
  input  logic             start,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [7:0]       in_re_index,
  input  logic [PWR_W-1:0] in_pwr,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [3:0]       out_seg,
  output logic [ACC_W-1:0] out_peak,
  output logic [7:0]       out_cnt,
  output logic             out_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_scs;
  logic               r_last_seen;
  logic               r_s1_vld;
  logic [3:0]         r_s1_seg;
  logic [PWR_W-1:0]   r_s1_pwr;
  logic [ACC_W-1:0]   r_bin [NSEG];
  logic [3:0]         r_k;
  logic [ACC_W-1:0]   r_best;
  logic [3:0]         r_best_seg;

  logic               w_start;
  logic               w_hs;
  logic               w_in_range;
  logic [3:0]         w_seg;
  logic [4:0]         w_mod_unused;
  logic [ACC_W:0]     w_sum;
  logic               w_scan_hit;
  logic               w_scan_done;

  ul_srch_90k u_map (
    .scs      (r_scs),
    .re_index (in_re_index),
    .seg      (w_seg),
    .mod      (w_mod_unused)
  );

  assign w_start     = start && (scs != SCS_INV);
  // Ready closes as soon as in_last is taken so the final bin update lands before SCAN.
  assign in_rdy      = (r_state == ST_ACC) && !r_last_seen;
  assign w_hs        = in_vld && in_rdy;
  assign w_in_range  = in_re_index < scs_re_limit(r_scs);
  assign w_sum       = {1'b0, r_bin[r_s1_seg]} + {{(ACC_W + 1 - PWR_W){1'b0}}, r_s1_pwr};
  assign w_scan_hit  = r_bin[r_k] > r_best;
  assign w_scan_done = (r_state == ST_SCAN) && (r_k == 4'(NSEG - 1));
  assign out_vld     = (r_state == ST_OUT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ACC;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_ACC:  if (r_last_seen) w_state_nxt = ST_SCAN;
        ST_SCAN: if (w_scan_done) w_state_nxt = ST_OUT;
        ST_OUT:  if (out_rdy)     w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_scs       <= rst ? SCS_INV : scs;
      r_last_seen <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_seg    <= '0;
      r_s1_pwr    <= '0;
      r_k         <= '0;
      r_best      <= '0;
      r_best_seg  <= '0;
      out_cnt     <= '0;
      out_err     <= 1'b0;
      for (int i = 0; i < NSEG; i++) r_bin[i] <= '0;
      if (rst) begin
        out_seg  <= '0;
        out_peak <= '0;
      end
    end else begin
      r_s1_vld <= w_hs && w_in_range;
      r_s1_seg <= w_seg;
      r_s1_pwr <= in_pwr;
      if (w_hs && !w_in_range) out_err <= 1'b1;
      if (w_hs && in_last)     r_last_seen <= 1'b1;

      // Single-stage read-modify-write: the prior update is already in r_bin.
      if (r_s1_vld) begin
        r_bin[r_s1_seg] <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
        if (out_cnt != 8'hFF) out_cnt <= out_cnt + 8'd1;
      end

      if ((r_state == ST_ACC) && r_last_seen) begin
        r_last_seen <= 1'b0;
        r_k         <= '0;
        r_best      <= '0;
        r_best_seg  <= '0;
      end

      if (r_state == ST_SCAN) begin
        if (w_scan_hit) begin
          r_best     <= r_bin[r_k];
          r_best_seg <= r_k;
        end
        r_k <= r_k + 4'd1;
        if (w_scan_done) begin
          r_k      <= '0;
          out_peak <= w_scan_hit ? r_bin[r_k] : r_best;
          out_seg  <= w_scan_hit ? r_k : r_best_seg;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ul_srch_90k_acc.md
# ul_srch_90k_acc

Per-symbol 90 kHz search-segment energy accumulator for the UL search path. It consumes a stream of per-RE power samples tagged with an RE index and bins each sample into one of 10 search segments according to SCS. At end of symbol it scans the bins and reports the strongest segment, its energy and the accepted-sample count over a valid/ready handshake.

## Interface
- PWR_W, 16, per-RE power width (unsigned)
- ACC_W, 24, segment accumulator width (unsigned, saturating)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- scs  in  2  1=5 kHz (gap 18), 2=15 kHz (gap 6), 3=30 kHz (gap 3), 0=invalid; sampled only on start
- start  in  1  one-cycle pulse; opens a new symbol
- in_vld  in  1  sample valid
- in_rdy  out  1  high only in ACC
- in_re_index  in  8  RE index within the 90 kHz window
- in_pwr  in  PWR_W  RE power
- in_last  in  1  marks last sample of symbol; qualified by in_vld&in_rdy
- out_vld  out  1  result valid; held until out_rdy
- out_rdy  in  1  downstream ready
- out_seg  out  4  peak segment 0..9
- out_peak  out  ACC_W  energy of peak segment
- out_cnt  out  8  in-range samples accumulated
- out_err  out  1  ≥1 sample dropped (out of range)

## Operation
- States: IDLE, ACC, SCAN, OUT. Reset → IDLE, all bins 0, all outputs 0, in_rdy=0.
- IDLE: start with scs≠0 → latch scs, clear 10 bins, out_cnt, out_err → ACC. start with scs=0 is ignored.
- start in ACC/SCAN/OUT with scs≠0: abort, drop pending result (out_vld falls next cycle), clear, → ACC. Highest priority after rst.
- ACC: handshake = in_vld&in_rdy. Stage 1 registers segment/pwr. Segment = re_index / gap, mod = re_index % gap. Valid range: re_index < 180/60/30 for scs 1/2/3. Out-of-range samples set out_err and are not accumulated or counted. Stage 2: bin[seg] += pwr, saturating at 2^ACC_W−1. out_cnt++ saturates at 255. Back-to-back same-segment samples must accumulate correctly (no RMW hazard).
- in_last handshake: ACC → SCAN on the following edge, after the last bin update.
- SCAN: one bin per cycle, k=0..9. Update best only if bin[k] > best (strict), so a tie resolves to the lowest index. All bins zero → out_seg=0, out_peak=0.
- OUT: out_vld=1; outputs stable until out_rdy. out_vld&out_rdy → IDLE, out_vld=0 next cycle. Outputs hold last values in IDLE.

## Timing
- Sample throughput: 1 per cycle in ACC.
- Bin update: 1 edge after acceptance.
- in_last accepted at edge T → SCAN from T+1 → out_vld high after edge T+11 (11-cycle latency), assuming no start.
- in_rdy drops the cycle after the in_last handshake. Samples presented outside ACC are ignored.
- rst mid-operation: IDLE on the next edge. Pending result lost; bins cleared.

## Structure
- Shared package ul_srch_pkg:
  - SCS codes
  - NSEG=10
  - per-SCS gap (18/6/3) and RE limit (180/60/30)
  - state enum
- Sub-module: existing combinational segment mapper ul_srch_90k (scs, re_index → 4-bit seg, 5-bit mod), instantiated unchanged in stage 1. The range check is local to this block.

## Test plan
- scs=2, start; 60 samples re 0..59, pwr=1, except re 30..35 pwr=100, last on re 59 → out_seg=5, out_peak=600, out_cnt=60, out_err=0, out_vld 11 cycles after last.
- scs=3; re 0..29, pwr=re_index → seg9 sum 27+28+29=84, out_seg=9, out_peak=84.
- scs=1; 18 samples in seg0 and 18 in seg4, equal pwr=7 (tie) → out_seg=0, out_peak=126. Then one sample re=180 → out_err=1, out_cnt unchanged.
- ACC_W overflow: 4 samples to one segment with pwr=0xFFFF and ACC_W=17 → out_peak=0x1FFFF (saturated).
- Hold out_rdy=0 for 20 cycles → outputs stable, out_vld held. Then start mid-OUT with scs=3 → out_vld=0 next cycle, bins cleared, new symbol correct.
- rst asserted during SCAN → IDLE, out_vld=0, in_rdy=0. start with scs=0 afterwards → remains IDLE.
